ibex_pext_mul16_seq: RTL

//  Multi-cycle execution unit for the Zpn 16x16 multiply class, downstream of the P-ext decoder.

---
 rtl/ibex_pkg_pext.sv | 105 ++++++++++
 rtl/ibex_pext_mul16.sv | 26 ++
 rtl/ibex_pext_mul16_seq.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/ibex_pkg_pext.sv
// ============================================================================
// Module  : ibex_pkg_pext
// Brief   : Zpn operator encoding and 16x16 multiply-class control decode.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ibex_pkg_pext;

    typedef enum logic [5:0] {
        ZPN_SMBB16, ZPN_SMBT16, ZPN_SMTT16,
        ZPN_KMABB,  ZPN_KMABT,  ZPN_KMATT,
        ZPN_KMDA,   ZPN_KMXDA,  ZPN_SMDS,   ZPN_SMDRS,  ZPN_SMXDS,
        ZPN_KMADA,  ZPN_KMAXDA, ZPN_KMADS,  ZPN_KMADRS, ZPN_KMAXDS,
        ZPN_KMSDA,  ZPN_KMSXDA,
        ZPN_ADD16,  ZPN_SUB16,  ZPN_KADD16, ZPN_SMMUL
    } zpn_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL1 = 2'd1,
        ACC  = 2'd2
    } pext_mul_state_e;

    typedef enum logic [1:0] {
        SEL_TT = 2'd0,
        SEL_BB = 2'd1,
        SEL_TB = 2'd2,
        SEL_BT = 2'd3
    } pext_mul_sel_e;

    typedef struct packed {
        pext_mul_sel_e sel0;
        pext_mul_sel_e sel1;
        logic          dual;
        logic          use_acc;
        logic          neg0;
        logic          neg1;
        logic          sat;
    } pext_mul_ctrl_t;

    function automatic pext_mul_ctrl_t pext_mul_mk(
        input pext_mul_sel_e sel0, input pext_mul_sel_e sel1,
        input logic dual, input logic use_acc,
        input logic neg0, input logic neg1, input logic sat
    );
        pext_mul_ctrl_t c;
        c.sel0    = sel0;
        c.sel1    = sel1;
        c.dual    = dual;
        c.use_acc = use_acc;
        c.neg0    = neg0;
        c.neg1    = neg1;
        c.sat     = sat;
        return c;
    endfunction

    function automatic logic pext_is_mul16(input zpn_op_e op);
        return (op inside {ZPN_SMBB16, ZPN_SMBT16, ZPN_SMTT16,
                           ZPN_KMABB, ZPN_KMABT, ZPN_KMATT,
                           ZPN_KMDA, ZPN_KMXDA, ZPN_SMDS, ZPN_SMDRS, ZPN_SMXDS,
                           ZPN_KMADA, ZPN_KMAXDA, ZPN_KMADS, ZPN_KMADRS,
                           ZPN_KMAXDS, ZPN_KMSDA, ZPN_KMSXDA});
    endfunction

    // Subtraction ops place the subtracted product in slot 1 (neg1) so the
    // shared multiplier always produces the positive term first.
    function automatic pext_mul_ctrl_t pext_mul_decode(input zpn_op_e op);
        pext_mul_ctrl_t c;
        c = pext_mul_mk(SEL_BB, SEL_BB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        case (op)
            ZPN_SMBB16: c = pext_mul_mk(SEL_BB, SEL_BB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            ZPN_SMBT16: c = pext_mul_mk(SEL_BT, SEL_BT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            ZPN_SMTT16: c = pext_mul_mk(SEL_TT, SEL_TT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            ZPN_KMABB:  c = pext_mul_mk(SEL_BB, SEL_BB, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
            ZPN_KMABT:  c = pext_mul_mk(SEL_BT, SEL_BT, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
            ZPN_KMATT:  c = pext_mul_mk(SEL_TT, SEL_TT, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
            ZPN_KMDA:   c = pext_mul_mk(SEL_TT, SEL_BB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            ZPN_KMXDA:  c = pext_mul_mk(SEL_TB, SEL_BT, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            ZPN_SMDS:   c = pext_mul_mk(SEL_TT, SEL_BB, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            ZPN_SMDRS:  c = pext_mul_mk(SEL_BB, SEL_TT, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            ZPN_SMXDS:  c = pext_mul_mk(SEL_TB, SEL_BT, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            ZPN_KMADA:  c = pext_mul_mk(SEL_TT, SEL_BB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
            ZPN_KMAXDA: c = pext_mul_mk(SEL_TB, SEL_BT, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
            ZPN_KMADS:  c = pext_mul_mk(SEL_TT, SEL_BB, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
            ZPN_KMADRS: c = pext_mul_mk(SEL_BB, SEL_TT, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
            ZPN_KMAXDS: c = pext_mul_mk(SEL_TB, SEL_BT, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
            ZPN_KMSDA:  c = pext_mul_mk(SEL_TT, SEL_BB, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
            ZPN_KMSXDA: c = pext_mul_mk(SEL_TB, SEL_BT, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
            default:    c = pext_mul_mk(SEL_BB, SEL_BB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        endcase
        return c;
    endfunction

    function automatic logic [15:0] pext_half_a(input pext_mul_sel_e sel, input logic [31:0] a);
        return (sel == SEL_TT || sel == SEL_TB) ? a[31:16] : a[15:0];
    endfunction

    function automatic logic [15:0] pext_half_b(input pext_mul_sel_e sel, input logic [31:0] b);
        return (sel == SEL_TT || sel == SEL_BT) ? b[31:16] : b[15:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/ibex_pext_mul16.sv
// ============================================================================
// Module  : ibex_pext_mul16
// Brief   : Combinational signed 16x16 -> 32 multiplier.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ibex_pext_mul16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [31:0] p_o
);

    logic signed [31:0] a_ext;
    logic signed [31:0] b_ext;

    // The low 32 bits of the extended product are exact for 16x16 operands.
    always_comb begin
        a_ext = {{16{a_i[15]}}, a_i};
        b_ext = {{16{b_i[15]}}, b_i};
        p_o   = a_ext * b_ext;
    end

endmodule

`default_nettype wire

// File: rtl/ibex_pext_mul16_seq.sv
// ============================================================================
// Module  : ibex_pext_mul16_seq
// Brief   : Multi-cycle Zpn 16x16 multiply / accumulate / Q31-saturate unit.
//           IBEX_PEXT_DUAL_MUL_EN selects two multipliers (all ops 2 cycles).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ibex_pext_mul16_seq
    import ibex_pkg_pext::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        mult_en_i,
    input  zpn_op_e     zpn_operator_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic [31:0] acc_i,
    output logic        valid_o,
    output logic [31:0] result_o,
    output logic        ov_o,
    output logic        unsupported_o
);

    pext_mul_state_e state_q, state_d;
    logic [31:0]     p0_q, p0_d;
    logic [31:0]     p1_q, p1_d;

    pext_mul_ctrl_t  ctrl;
    logic            supported;
    logic [31:0]     prod0;

    assign ctrl      = pext_mul_decode(zpn_operator_i);
    assign supported = pext_is_mul16(zpn_operator_i);

`ifdef IBEX_PEXT_DUAL_MUL_EN
    logic [31:0] prod1;

    ibex_pext_mul16 u_mul0 (
        .a_i (pext_half_a(ctrl.sel0, op_a_i)),
        .b_i (pext_half_b(ctrl.sel0, op_b_i)),
        .p_o (prod0)
    );

    ibex_pext_mul16 u_mul1 (
        .a_i (pext_half_a(ctrl.sel1, op_a_i)),
        .b_i (pext_half_b(ctrl.sel1, op_b_i)),
        .p_o (prod1)
    );
`else
    pext_mul_sel_e mul_sel;

    assign mul_sel = (state_q == MUL1) ? ctrl.sel1 : ctrl.sel0;

    ibex_pext_mul16 u_mul0 (
        .a_i (pext_half_a(mul_sel, op_a_i)),
        .b_i (pext_half_b(mul_sel, op_b_i)),
        .p_o (prod0)
    );
`endif

    always_comb begin
        state_d = state_q;
        p0_d    = p0_q;
        p1_d    = p1_q;
        case (state_q)
            IDLE: begin
                if (mult_en_i) begin
                    state_d = ACC;
                    if (supported) begin
                        p0_d = prod0;
`ifdef IBEX_PEXT_DUAL_MUL_EN
                        p1_d = prod1;
`else
                        if (ctrl.dual) begin
                            state_d = MUL1;
                        end
`endif
                    end
                end
            end
            MUL1: begin
                if (mult_en_i) begin
                    p1_d    = prod0;
                    state_d = ACC;
                end else begin
                    state_d = IDLE;
                end
            end
            ACC:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            p0_q    <= '0;
            p1_q    <= '0;
        end else begin
            state_q <= state_d;
            p0_q    <= p0_d;
            p1_q    <= p1_d;
        end
    end

    logic        valid;
    logic [33:0] acc_ext;
    logic [33:0] term0;
    logic [33:0] term1;
    logic [33:0] sum;
    logic        clamp_hi;
    logic        clamp_lo;
    logic [31:0] sat_res;

    // A 34-bit sum fits in Q31 only when bits [33:31] all agree.
    always_comb begin
        valid   = (state_q == ACC) && mult_en_i;
        acc_ext = ctrl.use_acc ? {{2{acc_i[31]}}, acc_i} : 34'd0;
        term0   = {{2{p0_q[31]}}, p0_q};
        if (ctrl.neg0) begin
            term0 = 34'd0 - term0;
        end
        term1 = ctrl.dual ? {{2{p1_q[31]}}, p1_q} : 34'd0;
        if (ctrl.neg1) begin
            term1 = 34'd0 - term1;
        end
        sum      = acc_ext + term0 + term1;
        clamp_hi = ctrl.sat && !sum[33] && (sum[32:31] != 2'b00);
        clamp_lo = ctrl.sat &&  sum[33] && (sum[32:31] != 2'b11);
        if (clamp_hi) begin
            sat_res = 32'h7FFF_FFFF;
        end else if (clamp_lo) begin
            sat_res = 32'h8000_0000;
        end else begin
            sat_res = sum[31:0];
        end

        valid_o       = valid;
        result_o      = (valid && supported) ? sat_res : 32'd0;
        ov_o          = valid && supported && (clamp_hi || clamp_lo);
        unsupported_o = valid && !supported;
    end

endmodule

`default_nettype wire
